// File: rtl/ofdm_frame_rx_pkg.sv
// Shared constants, FCH field layout and state encodings for the OFDM RX frame controller.
package ofdm_frame_rx_pkg;

    // Symbol geometry: cyclic prefix followed by one FFT block
    localparam int CP_LEN  = 8;
    localparam int FFT_LEN = 256;
    localparam int SYM_LEN = CP_LEN + FFT_LEN;

    // FCH symbol modulation
    localparam logic [1:0] BPSK_MOD = 2'd0;

    // FCH byte 0: reserved bit that must be zero
    localparam int FCH_B0_RSVD_BIT    = 6;
    // FCH byte 1: frame size low nibble and coding indicator
    localparam int FCH_B1_SIZE_LO_MSB = 7;
    localparam int FCH_B1_SIZE_LO_LSB = 4;
    localparam int FCH_B1_CODING_MSB  = 3;
    localparam int FCH_B1_CODING_LSB  = 1;
    // FCH byte 2: reserved high nibble, frame size high nibble
    localparam int FCH_B2_RSVD_MSB    = 7;
    localparam int FCH_B2_RSVD_LSB    = 4;
    localparam int FCH_B2_SIZE_HI_MSB = 3;
    localparam int FCH_B2_SIZE_HI_LSB = 0;

    // o_state_rx encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FCH  = 2'd1,
        ST_DATA = 2'd2
    } rx_state_t;

    // Flags a field violation in FCH byte 'idx'
    function automatic logic fch_byte_bad(input logic [1:0] idx, input logic [7:0] b);
        logic bad;
        bad = 1'b0;
        case (idx)
            2'd0:    bad = b[FCH_B0_RSVD_BIT];
            2'd1:    bad = |b[FCH_B1_CODING_MSB:FCH_B1_CODING_LSB];
            2'd2:    bad = |b[FCH_B2_RSVD_MSB:FCH_B2_RSVD_LSB];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ofdm_remove_cp.sv
// Sample counter, cyclic-prefix strip, symbol start/last flags and per-symbol FFT drop decision.
module ofdm_remove_cp
    import ofdm_frame_rx_pkg::*;
#(
    parameter int DATA_SIZE    = 16,
    parameter int SYMBOLS_SIZE = FFT_LEN,
    parameter int CP_LENGHT    = CP_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 fft_ready,
    input  logic                 symbol_is_fch,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data_i,
    output logic [DATA_SIZE-1:0] out_data_q,
    output logic                 out_symbol_start,
    output logic                 out_symbol_last,
    output logic                 out_symbol_is_fch,
    output logic                 rx_overflow,
    output logic                 symbol_done
);
    localparam int SYM_TOTAL = CP_LENGHT + SYMBOLS_SIZE;
    localparam int CNT_W     = $clog2(SYM_TOTAL);
    localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(CP_LENGHT);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SYM_TOTAL - 1);

    logic [CNT_W-1:0] sample_cnt;
    logic             drop;
    logic             accept;
    logic             at_first;
    logic             drop_now;
    logic             forward;

    // The drop decision is taken on the first useful sample and then held for the symbol
    assign accept      = in_valid & enable;
    assign at_first    = (sample_cnt == FIRST_IDX);
    assign drop_now    = at_first ? ~fft_ready : drop;
    assign forward     = accept & (sample_cnt >= FIRST_IDX) & ~drop_now & ~flush;
    assign symbol_done = accept & (sample_cnt == LAST_IDX);

    // Sample position within the symbol and the sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            drop       <= 1'b0;
        end else if (flush) begin
            sample_cnt <= '0;
            drop       <= 1'b0;
        end else if (accept) begin
            sample_cnt <= symbol_done ? '0 : sample_cnt + CNT_W'(1);
            if (at_first) begin
                drop <= ~fft_ready;
            end
        end
    end

    // One-cycle forwarding register with symbol flags and the overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data_i        <= '0;
            out_data_q        <= '0;
            out_symbol_start  <= 1'b0;
            out_symbol_last   <= 1'b0;
            out_symbol_is_fch <= 1'b0;
            rx_overflow       <= 1'b0;
        end else begin
            out_valid         <= forward;
            out_symbol_start  <= forward & at_first;
            out_symbol_last   <= forward & (sample_cnt == LAST_IDX);
            out_symbol_is_fch <= forward & symbol_is_fch;
            rx_overflow       <= accept & at_first & ~fft_ready & ~flush;
            if (forward) begin
                out_data_i <= in_data_i;
                out_data_q <= in_data_q;
            end
        end
    end

endmodule

// File: rtl/ofdm_frame_rx.sv
// OFDM RX frame controller: frame FSM, FCH decoder and completed-symbol counter around the CP stripper.
module ofdm_frame_rx
    import ofdm_frame_rx_pkg::*;
#(
    parameter int DATA_SIZE    = 16,
    parameter int SYMBOLS_SIZE = FFT_LEN,
    parameter int CP_LENGHT    = CP_LEN,
    parameter int FCH_TIMEOUT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 sync_detect,
    input  logic                 fft_ready,
    input  logic                 fch_valid,
    input  logic [7:0]           fch_data,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data_i,
    output logic [DATA_SIZE-1:0] out_data_q,
    output logic                 out_symbol_start,
    output logic                 out_symbol_last,
    output logic                 out_symbol_is_fch,
    output logic [7:0]           frame_size,
    output logic                 frame_size_valid,
    output logic                 done_receive,
    output logic                 fch_error,
    output logic                 rx_overflow,
    output logic [1:0]           o_state_rx
);
    rx_state_t  state, state_next;
    logic [8:0] sym_cnt;
    logic [1:0] byte_idx;
    logic       fch_bad_acc;
    logic [3:0] size_lo;

    logic start_frame;
    logic symbol_done;
    logic fch_take;
    logic fch_last;
    logic fch_bad_now;
    logic timeout;
    logic abort;
    logic frame_end;

    // Completion checks use the registered frame_size_valid, so a decode in the
    // same cycle as a completion only takes effect at the following completion.
    assign start_frame = (state == ST_IDLE) & in_valid & sync_detect;
    assign fch_take    = (state != ST_IDLE) & fch_valid & ~frame_size_valid;
    assign fch_last    = fch_take & (byte_idx == 2'd2);
    assign fch_bad_now = fch_bad_acc | fch_byte_bad(byte_idx, fch_data);
    assign timeout     = symbol_done & ~frame_size_valid & (sym_cnt == 9'(FCH_TIMEOUT));
    assign abort       = (fch_last & fch_bad_now) | timeout;
    assign frame_end   = symbol_done & frame_size_valid & (sym_cnt >= {1'b0, frame_size});
    assign o_state_rx  = state;

    ofdm_remove_cp #(
        .DATA_SIZE    (DATA_SIZE),
        .SYMBOLS_SIZE (SYMBOLS_SIZE),
        .CP_LENGHT    (CP_LENGHT)
    ) u_remove_cp (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_data_i         (in_data_i),
        .in_data_q         (in_data_q),
        .enable            ((state != ST_IDLE) | sync_detect),
        .flush             (abort),
        .fft_ready         (fft_ready),
        .symbol_is_fch     (sym_cnt == 9'd0),
        .out_valid         (out_valid),
        .out_data_i        (out_data_i),
        .out_data_q        (out_data_q),
        .out_symbol_start  (out_symbol_start),
        .out_symbol_last   (out_symbol_last),
        .out_symbol_is_fch (out_symbol_is_fch),
        .rx_overflow       (rx_overflow),
        .symbol_done       (symbol_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort and end of frame both return to IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_frame) state_next = ST_FCH;
            ST_FCH: begin
                if (abort | frame_end) state_next = ST_IDLE;
                else if (symbol_done)  state_next = ST_DATA;
            end
            ST_DATA: if (abort | frame_end) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Completed-symbol counter and end-of-frame / error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt      <= '0;
            done_receive <= 1'b0;
            fch_error    <= 1'b0;
        end else begin
            done_receive <= frame_end;
            fch_error    <= abort;
            if (start_frame | abort | frame_end) begin
                sym_cnt <= '0;
            end else if (symbol_done) begin
                sym_cnt <= sym_cnt + 9'd1;
            end
        end
    end

    // FCH byte decoder; the decoded size persists until the next frame starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx         <= '0;
            fch_bad_acc      <= 1'b0;
            size_lo          <= '0;
            frame_size       <= '0;
            frame_size_valid <= 1'b0;
        end else if (start_frame) begin
            byte_idx         <= '0;
            fch_bad_acc      <= 1'b0;
            size_lo          <= '0;
            frame_size       <= '0;
            frame_size_valid <= 1'b0;
        end else if (abort) begin
            byte_idx    <= '0;
            fch_bad_acc <= 1'b0;
        end else if (fch_take) begin
            byte_idx    <= byte_idx + 2'd1;
            fch_bad_acc <= fch_bad_now;
            if (byte_idx == 2'd1) begin
                size_lo <= fch_data[FCH_B1_SIZE_LO_MSB:FCH_B1_SIZE_LO_LSB];
            end
            if (fch_last) begin
                frame_size       <= {fch_data[FCH_B2_SIZE_HI_MSB:FCH_B2_SIZE_HI_LSB], size_lo};
                frame_size_valid <= 1'b1;
            end
        end
    end

endmodule
